// File: rtl/axi_pkg.sv
// Shared AXI encodings, engine state type and transfer-size helper
// used by the burst master and its segment calculator.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_RESP = 3'd3,
        ST_DONE = 3'd4
    } eng_state_t;

    function automatic logic [2:0] size_from_width(input int width);
        return 3'($clog2(width / 8));
    endfunction

endpackage

// File: rtl/axi_burst_split.sv
// Combinational segment calculator: beats for the next INCR burst
// (bounded by remaining, MAX_BURST and the 4 KB page) and the follow-on address.
module axi_burst_split
    import axi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 12,
    parameter int MAX_BURST = 256
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  remaining,
    output logic [8:0]        seg,
    output logic [7:0]        axlen,
    output logic [ADDR_W-1:0] next_addr,
    output logic [LEN_W-1:0]  next_remaining
);

    localparam int SZ = int'(size_from_width(DATA_W));
    localparam int CW = (LEN_W > 13) ? LEN_W : 13;

    logic [12:0]   page_beats;
    logic [CW-1:0] rem_w;
    logic [CW-1:0] page_w;
    logic [CW-1:0] max_w;
    logic [CW-1:0] seg_w;

    always_comb begin
        page_beats = (13'd4096 - {1'b0, addr[11:0]}) >> SZ;
        rem_w      = CW'(remaining);
        page_w     = CW'(page_beats);
        max_w      = CW'(MAX_BURST);
        seg_w      = rem_w;
        if (max_w < seg_w) seg_w = max_w;
        if (page_w < seg_w) seg_w = page_w;
        seg            = seg_w[8:0];
        axlen          = 8'(seg_w - 1'b1);
        next_addr      = addr + (ADDR_W'(seg) << SZ);
        next_remaining = remaining - LEN_W'(seg);
    end

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 master with independent read and write engines that split a user
// transfer into INCR bursts and report completion and sticky error status.
//
// state   | meaning
// IDLE    | waiting for a request with non-zero length
// ADDR    | AxVALID asserted for the current segment
// DATA    | read beats (RREADY) or write beats (WVALID) of the segment
// RESP    | write only: BREADY, waiting for the segment response
// DONE    | one-cycle completion pulse
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int LEN_W     = 12,
    parameter int MAX_BURST = 256,
    parameter int RD_ID     = 0,
    parameter int WR_ID     = 0
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    output logic [ID_W-1:0]     AWID,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [ID_W-1:0]     BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    output logic [ID_W-1:0]     ARID,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [7:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [ID_W-1:0]     RID,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [LEN_W-1:0]    rd_len,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_data_en,
    output logic                rd_last,
    output logic                rd_busy,
    output logic                rd_done,
    output logic                rd_err,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [LEN_W-1:0]    wr_len,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_data_en,
    output logic                wr_last,
    output logic                wr_busy,
    output logic                wr_done,
    output logic                wr_err
);

    localparam logic [2:0] AX_SIZE = size_from_width(DATA_W);
    localparam int         SZ      = int'(AX_SIZE);

    eng_state_t          rd_state, rd_state_nxt;
    eng_state_t          wr_state, wr_state_nxt;
    logic [ADDR_W-1:0]   rd_cur_addr, wr_cur_addr;
    logic [LEN_W-1:0]    rd_rem, wr_rem;
    logic [8:0]          rd_beats, wr_beats;
    logic [8:0]          rd_seg, wr_seg;
    logic [ADDR_W-1:0]   rd_next_addr, wr_next_addr;
    logic [LEN_W-1:0]    rd_next_rem, wr_next_rem;
    logic                rd_start, wr_start;
    logic                unused_inputs;

    assign unused_inputs = ^{RID, BID, rd_addr[SZ-1:0], wr_addr[SZ-1:0]};

    axi_burst_split #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)) u_rd_split (
        .addr(rd_cur_addr), .remaining(rd_rem), .seg(rd_seg), .axlen(ARLEN),
        .next_addr(rd_next_addr), .next_remaining(rd_next_rem)
    );

    axi_burst_split #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)) u_wr_split (
        .addr(wr_cur_addr), .remaining(wr_rem), .seg(wr_seg), .axlen(AWLEN),
        .next_addr(wr_next_addr), .next_remaining(wr_next_rem)
    );

    assign ARID    = ID_W'(RD_ID);
    assign ARADDR  = rd_cur_addr;
    assign ARSIZE  = AX_SIZE;
    assign ARBURST = BURST_INCR;
    assign AWID    = ID_W'(WR_ID);
    assign AWADDR  = wr_cur_addr;
    assign AWSIZE  = AX_SIZE;
    assign AWBURST = BURST_INCR;
    assign WDATA   = wr_data;
    assign WSTRB   = '1;

    assign rd_start   = (rd_state == ST_IDLE) && rd_req && (rd_len != '0);
    assign wr_start   = (wr_state == ST_IDLE) && wr_req && (wr_len != '0);
    assign rd_data    = RDATA;
    assign rd_data_en = RVALID & RREADY;
    assign rd_last    = rd_data_en && (rd_rem == '0) && (rd_beats == 9'd1);
    assign rd_busy    = (rd_state != ST_IDLE);
    assign rd_done    = (rd_state == ST_DONE);
    assign wr_data_en = WVALID & WREADY;
    assign wr_last    = wr_data_en && WLAST && (wr_rem == '0);
    assign wr_busy    = (wr_state != ST_IDLE);
    assign wr_done    = (wr_state == ST_DONE);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state <= ST_IDLE;
            wr_state <= ST_IDLE;
        end else begin
            rd_state <= rd_state_nxt;
            wr_state <= wr_state_nxt;
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        ARVALID      = 1'b0;
        RREADY       = 1'b0;
        case (rd_state)
            ST_IDLE: if (rd_start) rd_state_nxt = ST_ADDR;
            ST_ADDR: begin
                ARVALID = 1'b1;
                if (ARREADY) rd_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                RREADY = 1'b1;
                if (RVALID && RLAST) rd_state_nxt = (rd_rem != '0) ? ST_ADDR : ST_DONE;
            end
            default: rd_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_state_nxt = wr_state;
        AWVALID      = 1'b0;
        WVALID       = 1'b0;
        WLAST        = 1'b0;
        BREADY       = 1'b0;
        case (wr_state)
            ST_IDLE: if (wr_start) wr_state_nxt = ST_ADDR;
            ST_ADDR: begin
                AWVALID = 1'b1;
                if (AWREADY) wr_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                WVALID = 1'b1;
                WLAST  = (wr_beats == 9'd1);
                if (WREADY && (wr_beats == 9'd1)) wr_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                BREADY = 1'b1;
                if (BVALID) wr_state_nxt = (wr_rem != '0) ? ST_ADDR : ST_DONE;
            end
            default: wr_state_nxt = ST_IDLE;
        endcase
    end

    // Address/remaining advance at the address handshake, so during DATA
    // they already describe what is left after the current segment.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_cur_addr <= '0;
            rd_rem      <= '0;
            rd_beats    <= '0;
            rd_err      <= 1'b0;
        end else if (rd_start) begin
            rd_cur_addr <= {rd_addr[ADDR_W-1:SZ], {SZ{1'b0}}};
            rd_rem      <= rd_len;
            rd_err      <= 1'b0;
        end else if ((rd_state == ST_ADDR) && ARREADY) begin
            rd_cur_addr <= rd_next_addr;
            rd_rem      <= rd_next_rem;
            rd_beats    <= rd_seg;
        end else if (rd_data_en) begin
            rd_beats <= rd_beats - 9'd1;
            if (RRESP != RESP_OKAY) rd_err <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_cur_addr <= '0;
            wr_rem      <= '0;
            wr_beats    <= '0;
            wr_err      <= 1'b0;
        end else if (wr_start) begin
            wr_cur_addr <= {wr_addr[ADDR_W-1:SZ], {SZ{1'b0}}};
            wr_rem      <= wr_len;
            wr_err      <= 1'b0;
        end else if ((wr_state == ST_ADDR) && AWREADY) begin
            wr_cur_addr <= wr_next_addr;
            wr_rem      <= wr_next_rem;
            wr_beats    <= wr_seg;
        end else if (wr_data_en) begin
            wr_beats <= wr_beats - 9'd1;
        end else if ((wr_state == ST_RESP) && BVALID && (BRESP != RESP_OKAY)) begin
            wr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master: directed transfers against a simple
// AXI slave model, expected bursts/beats queued up front and checked by a monitor.
module tb_axi_burst_master;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic        rd_req, wr_req;
    logic [31:0] rd_addr, wr_addr, rd_data, wr_data;
    logic [11:0] rd_len, wr_len;
    logic        rd_data_en, rd_last, rd_busy, rd_done, rd_err;
    logic        wr_data_en, wr_last, wr_busy, wr_done, wr_err;

    axi_burst_master dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_data(rd_data),
        .rd_data_en(rd_data_en), .rd_last(rd_last), .rd_busy(rd_busy), .rd_done(rd_done), .rd_err(rd_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
        .wr_data_en(wr_data_en), .wr_last(wr_last), .wr_busy(wr_busy), .wr_done(wr_done), .wr_err(wr_err)
    );

    always #5 ACLK = ~ACLK;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    logic [39:0] exp_ar_q[$], exp_aw_q[$];
    logic [32:0] exp_r_q[$];
    logic [33:0] exp_w_q[$];
    bit          exp_rd_done_q[$], exp_wr_done_q[$];

    // slave model state
    logic [39:0] slv_ar_q[$];
    int          r_beat = 0, rd_xfer_beat = 0, err_rd_beat = -1;
    int          b_pending = 0, wr_idx = 0, wr_en_count = 0;
    logic [31:0] wr_base = 32'h0;
    logic [1:0]  bresp_cfg = 2'b00;
    bit          wready_toggle = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge ACLK);
        cyc = cyc + 1;
    end

    // AXI slave: samples handshakes at negedge, updates its outputs 1 after posedge
    initial begin
        logic        ar_hs, r_hs, w_hs, w_hs_last, b_hs;
        logic [39:0] arv, cur;
        ARREADY = 1'b1; AWREADY = 1'b1; WREADY = 1'b0;
        RVALID = 1'b0; RLAST = 1'b0; RDATA = '0; RRESP = 2'b00; RID = '0;
        BVALID = 1'b0; BRESP = 2'b00; BID = '0;
        forever begin
            @(negedge ACLK);
            ar_hs = ARVALID && ARREADY;
            arv = {ARADDR, ARLEN};
            r_hs = RVALID && RREADY;
            w_hs = wr_data_en;
            w_hs_last = WVALID && WREADY && WLAST;
            b_hs = BVALID && BREADY;
            @(posedge ACLK);
            #1;
            if (!ARESETn) begin
                slv_ar_q.delete();
                r_beat = 0; b_pending = 0; wr_idx = 0;
                RVALID = 1'b0; RLAST = 1'b0; BVALID = 1'b0; WREADY = 1'b0;
                continue;
            end
            if (ar_hs) slv_ar_q.push_back(arv);
            if (r_hs) begin
                rd_xfer_beat++;
                if (RLAST) begin
                    void'(slv_ar_q.pop_front());
                    r_beat = 0;
                end else r_beat++;
            end
            if (w_hs) wr_idx++;
            if (w_hs_last) b_pending++;
            if (b_hs) b_pending--;
            if (slv_ar_q.size() > 0) begin
                cur = slv_ar_q[0];
                RVALID = 1'b1;
                RDATA = cur[39:8] + 32'(r_beat * 4);
                RLAST = (r_beat == int'(cur[7:0]));
                RRESP = (rd_xfer_beat == err_rd_beat) ? 2'b10 : 2'b00;
            end else begin
                RVALID = 1'b0;
                RLAST = 1'b0;
            end
            BVALID = (b_pending > 0);
            BRESP = bresp_cfg;
            WREADY = wready_toggle ? ~WREADY : 1'b1;
            wr_data = wr_base + 32'(wr_idx);
        end
    end

    // monitor / scoreboard
    initial begin
        int          rd_last_cyc = -10, b_cyc = -10;
        bit          prev_stall = 0, e;
        logic [31:0] prev_wdata = '0;
        logic        prev_wlast = 0;
        logic [39:0] ea;
        logic [32:0] er;
        logic [33:0] ew;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                prev_stall = 0;
                continue;
            end
            if (ARVALID && ARREADY) begin
                chk("ar_expected", exp_ar_q.size() > 0, 1);
                if (exp_ar_q.size() > 0) begin
                    ea = exp_ar_q.pop_front();
                    chk("araddr", ARADDR, ea[39:8]);
                    chk("arlen", ARLEN, ea[7:0]);
                    chk("arsize_burst_id", {ARSIZE, ARBURST, ARID}, {3'd2, 2'b01, 4'd0});
                end
            end
            if (rd_data_en) begin
                chk("r_expected", exp_r_q.size() > 0, 1);
                if (exp_r_q.size() > 0) begin
                    er = exp_r_q.pop_front();
                    chk("rd_data", rd_data, er[31:0]);
                    chk("rd_last", rd_last, er[32]);
                end
                if (rd_last) rd_last_cyc = cyc;
            end
            if (rd_done) begin
                chk("rd_done_expected", exp_rd_done_q.size() > 0, 1);
                if (exp_rd_done_q.size() > 0) begin
                    e = exp_rd_done_q.pop_front();
                    chk("rd_err", rd_err, e);
                end
                chk("rd_done_timing", cyc, rd_last_cyc + 1);
            end
            if (AWVALID && AWREADY) begin
                chk("aw_expected", exp_aw_q.size() > 0, 1);
                if (exp_aw_q.size() > 0) begin
                    ea = exp_aw_q.pop_front();
                    chk("awaddr", AWADDR, ea[39:8]);
                    chk("awlen", AWLEN, ea[7:0]);
                    chk("awsize_burst_id", {AWSIZE, AWBURST, AWID}, {3'd2, 2'b01, 4'd0});
                end
            end
            if (prev_stall) begin
                chk("w_hold_valid", WVALID, 1);
                chk("w_hold_data", WDATA, prev_wdata);
                chk("w_hold_last", WLAST, prev_wlast);
            end
            prev_stall = WVALID && !WREADY;
            prev_wdata = WDATA;
            prev_wlast = WLAST;
            if (wr_data_en) begin
                wr_en_count++;
                chk("w_expected", exp_w_q.size() > 0, 1);
                if (exp_w_q.size() > 0) begin
                    ew = exp_w_q.pop_front();
                    chk("wdata", WDATA, ew[31:0]);
                    chk("wlast", WLAST, ew[32]);
                    chk("wr_last", wr_last, ew[33]);
                    chk("wstrb", WSTRB, 4'hF);
                end
            end
            if (BVALID && BREADY) b_cyc = cyc;
            if (wr_done) begin
                chk("wr_done_expected", exp_wr_done_q.size() > 0, 1);
                if (exp_wr_done_q.size() > 0) begin
                    e = exp_wr_done_q.pop_front();
                    chk("wr_err", wr_err, e);
                end
                chk("wr_done_timing", cyc, b_cyc + 1);
            end
        end
    end

    task automatic exp_read(input logic [31:0] addr, input int len, input bit err);
        for (int i = 0; i < len; i++)
            exp_r_q.push_back({(i == len - 1), addr + 32'(4 * i)});
        exp_rd_done_q.push_back(err);
    endtask

    task automatic exp_write(input logic [31:0] base, input int len, input int seg0, input bit err);
        for (int i = 0; i < len; i++)
            exp_w_q.push_back({(i == len - 1), ((i == seg0 - 1) || (i == len - 1)), base + 32'(i)});
        exp_wr_done_q.push_back(err);
    endtask

    task automatic go(input bit do_rd, input logic [31:0] ra, input logic [11:0] rl,
                      input bit do_wr, input logic [31:0] wa, input logic [11:0] wl);
        @(posedge ACLK);
        #1;
        if (do_rd) begin
            rd_xfer_beat = 0;
            rd_req = 1'b1; rd_addr = ra; rd_len = rl;
        end
        if (do_wr) begin
            wr_idx = 0;
            wr_data = wr_base;
            wr_req = 1'b1; wr_addr = wa; wr_len = wl;
        end
        @(posedge ACLK);
        #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cyc);
        bit ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge ACLK);
            #2;
            if (exp_ar_q.size() == 0 && exp_r_q.size() == 0 && exp_rd_done_q.size() == 0 &&
                exp_aw_q.size() == 0 && exp_w_q.size() == 0 && exp_wr_done_q.size() == 0 &&
                !rd_busy && !wr_busy) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    initial begin
        bit seen;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        ARESETn = 1'b0;
        rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; rd_len = '0; wr_len = '0; wr_data = '0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("reset_outputs", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rd_busy, wr_busy,
                              rd_done, wr_done, rd_err, wr_err}, 11'd0);
        ARESETn = 1'b1;

        // zero length ignored
        go(1, 32'h100, 12'd0, 1, 32'h100, 12'd0);
        chk("len0_ignored", {rd_busy, wr_busy}, 2'b00);

        // single read burst
        exp_ar_q.push_back({32'h100, 8'd3});
        exp_read(32'h100, 4, 0);
        go(1, 32'h100, 12'd4, 0, 0, 0);
        chk("rd_busy_after_req", rd_busy, 1);
        drain("drain_rd_single", 100);

        // read crossing 4 KB page
        exp_ar_q.push_back({32'hFF8, 8'd1});
        exp_ar_q.push_back({32'h1000, 8'd3});
        exp_read(32'hFF8, 6, 0);
        go(1, 32'hFF8, 12'd6, 0, 0, 0);
        drain("drain_rd_4k", 100);

        // long write split by MAX_BURST; second request while busy is ignored
        wr_base = 32'hA000_0000;
        wr_en_count = 0;
        exp_aw_q.push_back({32'h0, 8'd255});
        exp_aw_q.push_back({32'h400, 8'd43});
        exp_write(wr_base, 300, 256, 0);
        go(0, 0, 0, 1, 32'h0, 12'd300);
        repeat (10) @(posedge ACLK);
        #1;
        wr_req = 1'b1; wr_addr = 32'h8000; wr_len = 12'd5;
        @(posedge ACLK);
        #1;
        wr_req = 1'b0;
        drain("drain_wr_300", 1000);
        chk("wr_beat_count", wr_en_count, 300);

        // write with WREADY toggling
        wr_base = 32'hB000_0000;
        wready_toggle = 1;
        exp_aw_q.push_back({32'h2000, 8'd7});
        exp_write(wr_base, 8, 8, 0);
        go(0, 0, 0, 1, 32'h2000, 12'd8);
        drain("drain_wr_stall", 200);
        wready_toggle = 0;

        // simultaneous read with SLVERR and write with DECERR
        wr_base = 32'hC000_0000;
        err_rd_beat = 1;
        bresp_cfg = 2'b11;
        exp_ar_q.push_back({32'h300, 8'd3});
        exp_read(32'h300, 4, 1);
        exp_aw_q.push_back({32'h500, 8'd1});
        exp_write(wr_base, 2, 2, 1);
        go(1, 32'h300, 12'd4, 1, 32'h500, 12'd2);
        drain("drain_err", 100);
        chk("err_sticky", {rd_err, wr_err}, 2'b11);
        err_rd_beat = -1;
        bresp_cfg = 2'b00;

        // clean transfers clear the sticky errors
        wr_base = 32'hD000_0000;
        exp_ar_q.push_back({32'h400, 8'd0});
        exp_read(32'h400, 1, 0);
        exp_aw_q.push_back({32'h600, 8'd2});
        exp_write(wr_base, 3, 3, 0);
        go(1, 32'h400, 12'd1, 1, 32'h600, 12'd3);
        chk("err_cleared_on_req", {rd_err, wr_err}, 2'b00);
        drain("drain_clean", 100);

        // reset during W phase
        wr_base = 32'hE000_0000;
        exp_aw_q.push_back({32'h3000, 8'd15});
        exp_write(wr_base, 16, 16, 0);
        go(0, 0, 0, 1, 32'h3000, 12'd16);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge ACLK);
            #1;
            if (WVALID && wr_en_count >= 300 + 8 + 2 + 3 + 3) begin
                seen = 1;
                break;
            end
        end
        chk("reached_w_phase", seen, 1);
        #2;
        exp_w_q.delete();
        exp_wr_done_q.delete();
        ARESETn = 1'b0;
        #1;
        chk("reset_async_drop", {AWVALID, WVALID, BREADY, wr_busy}, 4'b0000);
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        repeat (10) @(posedge ACLK);
        #1;
        chk("busy_after_reset", {wr_busy, rd_busy, wr_done}, 3'b000);
        drain("drain_after_reset", 20);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
